// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the SDRAM driver arbiter.
//   arb_state_t          - transaction FSM state (idle / issue / wait)
//   REQ_VGA/DATA/FETCH   - fixed requester index roles
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam int REQ_VGA   = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_FETCH = 2;

endpackage

// File: rtl/arb_select.sv
// arb_select: combinational winner selection for mem_arbiter.
//   req_valid   - per-requester request flags
//   vga_streak  - consecutive VGA grants (saturating)
//   rr_last     - index of the CPU port granted last (1 or 2)
//   grant       - one-hot winner, all zero when nothing is requesting
//   grant_valid - a winner exists
module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ         = 3,
    parameter int VGA_BURST_MAX = 4,
    parameter int STREAK_W      = 3
) (
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [STREAK_W-1:0] vga_streak,
    input  logic [1:0]          rr_last,
    output logic [N_REQ-1:0]    grant,
    output logic                grant_valid
);

    logic cpu_any;
    logic vga_blocked;

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant       = '0;
        cpu_any     = req_valid[REQ_DATA] | req_valid[REQ_FETCH];
        // VGA yields only when its streak is exhausted and the CPU is waiting.
        vga_blocked = (vga_streak == STREAK_W'(VGA_BURST_MAX)) && cpu_any;

        if (req_valid[REQ_VGA] && !vga_blocked) begin
            grant[REQ_VGA] = 1'b1;
        end else if (req_valid[REQ_DATA] && req_valid[REQ_FETCH]) begin
            // Tie between CPU ports: the one not served last goes next.
            if (rr_last == 2'(REQ_FETCH)) grant[REQ_DATA]  = 1'b1;
            else                          grant[REQ_FETCH] = 1'b1;
        end else if (req_valid[REQ_DATA]) begin
            grant[REQ_DATA] = 1'b1;
        end else if (req_valid[REQ_FETCH]) begin
            grant[REQ_FETCH] = 1'b1;
        end

        grant_valid = |grant;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises VGA, CPU data and CPU fetch requests onto one
// SDRAM driver, one transaction at a time.
//   req_valid/req_wr/req_addr/req_wdata - packed requester command ports
//   req_ready  - one-hot acceptance strobe (combinational, IDLE only)
//   rsp_valid  - one-hot completion pulse, rsp_data holds read data
//   drv_req/drv_wr/drv_addr/drv_wdata   - command to driver
//   drv_busy/drv_done/drv_rdata         - driver handshake and read data
//   grant_id   - index of current/last owner (debug)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int N_REQ         = 3,
    parameter int VGA_BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_wr,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        drv_req,
    output logic                        drv_wr,
    output logic [ADDR_WIDTH-1:0]       drv_addr,
    output logic [DATA_WIDTH-1:0]       drv_wdata,
    input  logic                        drv_busy,
    input  logic                        drv_done,
    input  logic [DATA_WIDTH-1:0]       drv_rdata,
    output logic [1:0]                  grant_id
);

    localparam int STREAK_W = $clog2(VGA_BURST_MAX + 1);

    arb_state_t          state;
    logic [N_REQ-1:0]    owner;
    logic [STREAK_W-1:0] vga_streak;
    logic [1:0]          rr_last;
    logic [N_REQ-1:0]    grant;
    logic                grant_valid;
    logic [1:0]          win_id;

    arb_select #(
        .N_REQ         (N_REQ),
        .VGA_BURST_MAX (VGA_BURST_MAX),
        .STREAK_W      (STREAK_W)
    ) u_select (
        .req_valid   (req_valid),
        .vga_streak  (vga_streak),
        .rr_last     (rr_last),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_id = 2'(i);
        end
    end

    // Acceptance and the driver strobe must land in the same cycle as the
    // state/busy condition, so they are decoded rather than registered.
    assign req_ready = (state == ARB_IDLE) ? grant : '0;
    assign drv_req   = (state == ARB_ISSUE) && !drv_busy;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            drv_wr     <= 1'b0;
            drv_addr   <= '0;
            drv_wdata  <= '0;
            grant_id   <= '0;
            vga_streak <= '0;
            rr_last    <= 2'(REQ_FETCH);
            rsp_valid  <= '0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= '0;
            unique case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        drv_wr    <= req_wr[win_id];
                        drv_addr  <= req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
                        drv_wdata <= req_wdata[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                        owner     <= grant;
                        grant_id  <= win_id;
                        if (grant[REQ_VGA]) begin
                            if (vga_streak != STREAK_W'(VGA_BURST_MAX))
                                vga_streak <= vga_streak + STREAK_W'(1);
                        end else begin
                            vga_streak <= '0;
                            rr_last    <= win_id;
                        end
                        state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (!drv_busy) state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (drv_done) begin
                        rsp_valid <= owner;
                        rsp_data  <= drv_rdata;
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_wr;
    logic [47:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        drv_req;
    logic        drv_wr;
    logic [15:0] drv_addr;
    logic [15:0] drv_wdata;
    logic        drv_busy;
    logic        drv_done;
    logic [15:0] drv_rdata;
    logic [1:0]  grant_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .drv_req   (drv_req),
        .drv_wr    (drv_wr),
        .drv_addr  (drv_addr),
        .drv_wdata (drv_wdata),
        .drv_busy  (drv_busy),
        .drv_done  (drv_done),
        .drv_rdata (drv_rdata),
        .grant_id  (grant_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Applies reset for two cycles, checks reset outputs, releases it.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        drv_busy  = 1'b0;
        drv_done  = 1'b0;
        drv_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst rsp_valid", 32'(rsp_valid), 0);
        check("rst drv_req", 32'(drv_req), 0);
        check("rst grant_id", 32'(grant_id), 0);
        rst_n = 1'b1;
    endtask

    // One full transaction with a ready driver, entered from an IDLE cycle.
    // Leaves the bench in the completion cycle (also an IDLE cycle).
    task automatic txn(input logic [2:0] v, input logic [2:0] exp_ready, input string tag);
        req_valid = v;
        drv_done  = 1'b0;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
        step();                       // ISSUE
        check({tag, " grant_id"}, 32'(grant_id), 32'(onehot_to_id(exp_ready)));
        step();                       // WAIT
        drv_done  = 1'b1;
        drv_rdata = 16'h5A5A;
        step();                       // completion / IDLE
        drv_done  = 1'b0;
        #1;
        check({tag, " rsp"}, 32'(rsp_valid), 32'(exp_ready));
    endtask

    initial begin
        // ---- single CPU data read, driver latency 5 ----
        do_reset();
        @(negedge clk);
        req_addr[16 +: 16] = 16'h0030;
        req_valid = 3'b010;
        #1;
        check("rd c0 ready", 32'(req_ready), 32'b010);
        step();                       // c1
        req_valid = 3'b000;
        #1;
        check("rd c1 drv_req", 32'(drv_req), 1);
        check("rd c1 addr", 32'(drv_addr), 32'h0030);
        check("rd c1 wr", 32'(drv_wr), 0);
        step();                       // c2
        check("rd c2 drv_req", 32'(drv_req), 0);
        repeat (4) step();            // c6
        drv_done  = 1'b1;
        drv_rdata = 16'hBEEF;
        #1;
        check("rd c6 rsp", 32'(rsp_valid), 0);
        step();                       // c7
        drv_done = 1'b0;
        #1;
        check("rd c7 rsp", 32'(rsp_valid), 32'b010);
        check("rd c7 data", 32'(rsp_data), 32'hBEEF);
        step();                       // c8
        check("rd c8 rsp", 32'(rsp_valid), 0);

        // ---- VGA vs fetch, streak limit 4 ----
        do_reset();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) txn(3'b101, 3'b001, $sformatf("vgaf r%0d v%0d", r, k));
            txn(3'b101, 3'b100, $sformatf("vgaf r%0d cpu", r));
        end

        // ---- streak saturates with VGA alone, CPU wins immediately ----
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) txn(3'b001, 3'b001, $sformatf("vsat %0d", k));
        txn(3'b101, 3'b100, "vsat cpu");
        txn(3'b101, 3'b001, "vsat back");

        // ---- data vs fetch round robin, data first ----
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            txn(3'b110, (k % 2 == 0) ? 3'b010 : 3'b100, $sformatf("rr %0d", k));

        // ---- all three valid: exactly one ready bit ----
        txn(3'b111, 3'b001, "all3");

        // ---- driver busy for three cycles ----
        do_reset();
        @(negedge clk);
        req_valid = 3'b010;
        drv_busy  = 1'b1;
        #1;
        check("busy ready", 32'(req_ready), 32'b010);
        step();
        req_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("busy hold %0d", k), 32'(drv_req), 0);
            step();
        end
        drv_busy = 1'b0;
        #1;
        check("busy issue", 32'(drv_req), 1);
        step();
        check("busy no repeat", 32'(drv_req), 0);
        drv_done = 1'b1;
        step();
        drv_done = 1'b0;
        #1;
        check("busy rsp", 32'(rsp_valid), 32'b010);

        // ---- fetch-port write; inputs changed after acceptance are ignored ----
        do_reset();
        @(negedge clk);
        req_wr[2]           = 1'b1;
        req_addr[32 +: 16]  = 16'hFFFF;
        req_wdata[32 +: 16] = 16'h1234;
        req_valid           = 3'b100;
        #1;
        check("wr ready", 32'(req_ready), 32'b100);
        step();
        req_valid = 3'b000;
        req_wr    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        check("wr drv_req", 32'(drv_req), 1);
        check("wr drv_wr", 32'(drv_wr), 1);
        check("wr addr", 32'(drv_addr), 32'hFFFF);
        check("wr wdata", 32'(drv_wdata), 32'h1234);
        step();
        drv_done = 1'b1;
        step();
        drv_done = 1'b0;
        #1;
        check("wr rsp", 32'(rsp_valid), 32'b100);

        // ---- reset while in WAIT, stray done afterwards ----
        do_reset();
        @(negedge clk);
        req_addr[16 +: 16] = 16'h0777;
        req_valid = 3'b010;
        step();                       // ISSUE
        req_valid = 3'b000;
        step();                       // WAIT
        rst_n = 1'b0;
        #1;
        check("mid rst rsp", 32'(rsp_valid), 0);
        check("mid rst addr", 32'(drv_addr), 0);
        check("mid rst gid", 32'(grant_id), 0);
        step();
        rst_n    = 1'b1;
        drv_done = 1'b1;
        step();
        drv_done = 1'b0;
        #1;
        check("stray rsp", 32'(rsp_valid), 0);
        check("stray drv_req", 32'(drv_req), 0);
        step();
        check("stray rsp2", 32'(rsp_valid), 0);
        check("stray drv_req2", 32'(drv_req), 0);
        txn(3'b110, 3'b010, "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single SDRAM memory driver between three requesters: VGA framebuffer fetch, CPU data port and CPU instruction fetch. Sits inside the memory controller, between the requester ports and the driver's request/done interface. Serialises one transaction at a time. Arbitration order:
- VGA has priority, but a starvation limit stops it locking out the CPU.
- The two CPU ports alternate round-robin.

## Interface
Parameters:
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 16, data width
- N_REQ, 3, requester count; index roles fixed (0 VGA, 1 CPU data, 2 CPU fetch)
- VGA_BURST_MAX, 4, max consecutive VGA grants while a CPU request is pending

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request
- req_wr  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data
- req_ready  out  N_REQ  one-hot acceptance strobe
- rsp_valid  out  N_REQ  one-hot completion pulse (reads and writes)
- rsp_data  out  DATA_WIDTH  read data, valid with rsp_valid
- drv_req  out  1  one-cycle command strobe to driver
- drv_wr  out  1  command direction
- drv_addr  out  ADDR_WIDTH  command address
- drv_wdata  out  DATA_WIDTH  command write data
- drv_busy  in  1  driver cannot accept a command
- drv_done  in  1  one-cycle completion; drv_rdata valid this cycle
- drv_rdata  in  DATA_WIDTH  driver read data
- grant_id  out  2  index of current/last owner (debug)

## Operation
The arbiter is a three-state FSM: IDLE, ISSUE, WAIT.

- **IDLE**
  - If any req_valid is high: pick winner w, latch req_wr/addr/wdata[w], assert req_ready[w] this cycle (combinational from state and valid), set grant_id = w, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - If drv_busy = 0: drv_req = 1 for exactly this cycle with the latched command, then go to WAIT.
  - Otherwise hold in ISSUE with drv_req = 0.
- **WAIT**
  - On drv_done: register drv_rdata into rsp_data, pulse rsp_valid[w] on the next cycle, go to IDLE.
  - Writes pulse rsp_valid as well; rsp_data is don't-care for writes.

Winner selection:
- VGA (0) wins if requesting, unless vga_streak == VGA_BURST_MAX and req 1 or 2 is valid. In that case the CPU side wins.
- vga_streak:
  - increments on each VGA grant, saturating at VGA_BURST_MAX;
  - clears on any CPU grant;
  - is unchanged by IDLE cycles.
- CPU side: if only one of 1/2 is valid, it wins. If both are valid, the one not granted last wins (rr_last).
- rr_last updates only on CPU grants.

Requester and driver rules:
- A requester may drop req_valid before acceptance.
- After acceptance, the requester's inputs are ignored until its rsp_valid.
- drv_done outside WAIT is ignored.
- drv_busy is sampled only in ISSUE.

## Timing
- Reset values: all outputs 0, state IDLE, vga_streak 0, rr_last = 2 (CPU data wins the first tie).
- Acceptance at cycle 0 gives the earliest drv_req at cycle 1.
- drv_done at cycle k gives rsp_valid at cycle k+1.
- The rsp_valid cycle is also an IDLE cycle, so a new req_ready can coincide with it (back-to-back, no bubble).
- Reset mid-transaction: abandon immediately. No rsp_valid is issued, and no drv_req after reset deassertion until a new acceptance.
- Simultaneous valid on all three requesters: exactly one req_ready bit is high, never more.

## Structure
- Package mem_arbiter_pkg holds:
  - state enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT)
  - index constants REQ_VGA = 0, REQ_DATA = 1, REQ_FETCH = 2
- Sub-module arb_select: purely combinational. Takes req_valid, vga_streak and rr_last, and produces a one-hot grant plus a valid flag.
- The FSM, latches, streak counter and rr_last live in mem_arbiter.

## Test plan
- Single CPU data read of 0x0030 with driver latency 5: req_ready[1] at c0, drv_req at c1 with addr 0x0030, drv_done at c6 returning 0xBEEF → rsp_valid = 3'b010 and rsp_data = 0xBEEF at c7.
- VGA and fetch both requesting continuously, VGA_BURST_MAX = 4 → grant order 0,0,0,0,2,0,0,0,0,2…
- Data and fetch both requesting continuously, VGA idle → grants alternate 1,2,1,2, with 1 first after reset.
- drv_busy held high for 3 cycles after acceptance → drv_req is asserted once, on the first cycle busy = 0, never earlier or repeated.
- Write by fetch port to 0xFFFF with data 0x1234 → drv_wr = 1, drv_addr = 0xFFFF, drv_wdata = 0x1234; rsp_valid = 3'b100 one cycle after drv_done.
- rst_n asserted while in WAIT, followed by a stray drv_done after release → no rsp_valid, outputs stay at reset values, and the next request is serviced normally.
